// File: rtl/dram_bank.sv
// Single-port data memory with byte-strobed writes, pipelined reads of
// configurable latency, an optional post-reset clear sweep and access-error reporting.
module dram_bank #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 8192,
    parameter int ADDR_W         = 17,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int NB   = DATA_W / 8;
    localparam int OFF  = $clog2(NB);
    localparam int MAW  = $clog2(DEPTH);
    localparam int WI_W = ADDR_W - OFF;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t         state_q, state_d;
    logic [MAW:0]   clr_cnt_q, clr_cnt_d;
    logic           clr_we;

    logic [WI_W-1:0] widx;
    logic [MAW-1:0]  midx;
    logic            misalign, oor, err;
    logic            accept, wr_en, rd_en;
    logic [NB-1:0]   lane_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              valid_q [RD_LAT];
    logic              err_q   [RD_LAT];
    logic [DATA_W-1:0] data_q  [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The counter's top bit marks that every word has been written once.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                if (CLEAR_ON_RESET == 0 || clr_cnt_q[MAW]) begin
                    state_d = S_READY;
                end else begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + (MAW+1)'(1);
                end
            end
            default: state_d = S_READY;
        endcase
    end

    assign req_ready = (state_q == S_READY);
    assign init_done = (state_q == S_READY);

    assign widx = req_addr[ADDR_W-1:OFF];
    assign midx = widx[MAW-1:0];

    generate
        if (OFF > 0) begin : g_mis
            assign misalign = |req_addr[OFF-1:0];
        end else begin : g_nomis
            assign misalign = 1'b0;
        end
        if (WI_W > MAW) begin : g_oor
            assign oor = |widx[WI_W-1:MAW];
        end else begin : g_nooor
            assign oor = 1'b0;
        end
    endgenerate

    assign err    = misalign | oor;
    assign accept = req_valid & req_ready;
    assign wr_en  = accept & req_we & ~err;
    assign rd_en  = accept & ~req_we & ~err;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = wr_en & req_be[gi];
        end
    endgenerate

    // No reset on the array so contents survive reset when the sweep is disabled.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q[MAW-1:0]] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (lane_we[b]) mem[midx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    // Payload stages only load on a valid entry, so the last stage holds its value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                valid_q[k] <= 1'b0;
                err_q[k]   <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q[0] <= accept;
            if (accept) begin
                err_q[0]  <= err;
                data_q[0] <= rd_en ? mem[midx] : '0;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    err_q[k]  <= err_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign rsp_valid = valid_q[RD_LAT-1];
    assign rsp_err   = err_q[RD_LAT-1];
    assign rsp_rdata = data_q[RD_LAT-1];
endmodule

// File: tb/tb_dram_bank.sv
// Bench for dram_bank: four instances (latencies 1/3/2/1, last without clear sweep),
// directed scenarios plus randomized traffic against a word-array model.
module tb_dram_bank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [4];
    logic        req_we;
    logic [16:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        req_ready [4];
    logic        rsp_valid [4];
    logic        rsp_err   [4];
    logic        init_done [4];
    logic [15:0] rsp_rdata [4];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic        err;
        logic [15:0] data;
    } rsp_t;

    rsp_t obs_q[$];
    rsp_t exp_q[$];
    logic [15:0] model_mem [3][64];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            dram_bank #(
                .DATA_W(16), .DEPTH(64), .ADDR_W(17),
                .RD_LAT((gi == 1) ? 3 : (gi == 2) ? 2 : 1),
                .CLEAR_ON_RESET((gi == 3) ? 0 : 1)
            ) u_dut (
                .clk(clk), .rst(rst),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
                .req_we(req_we), .req_addr(req_addr),
                .req_wdata(req_wdata), .req_be(req_be),
                .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]),
                .rsp_err(rsp_err[gi]), .init_done(init_done[gi])
            );
        end
    endgenerate

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i] === 1'b1)
                obs_q.push_back('{inst: i, cyc: cyc, err: rsp_err[i], data: rsp_rdata[i]});
        end
    end

    function automatic int lat_of(input int i);
        return (i == 1) ? 3 : (i == 2) ? 2 : 1;
    endfunction

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) req_valid[i] = 1'b0;
    endtask

    task automatic drive(input int i, input logic we, input logic [16:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        req_valid[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_and_init();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(66);
    endtask

    task automatic test_reset();
        int c0;
        bit expd;
        wait_cycles(2);
        for (int i = 0; i < 4; i++) begin
            vectors += 5;
            if (req_ready[i] !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready[%0d] got %b want 0", i, req_ready[i]); end
            if (rsp_valid[i] !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid[%0d] got %b want 0", i, rsp_valid[i]); end
            if (rsp_rdata[i] !== 16'h0) begin miscompares++; $display("FAIL reset_rsp_rdata[%0d] got %h want 0000", i, rsp_rdata[i]); end
            if (rsp_err[i] !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err[%0d] got %b want 0", i, rsp_err[i]); end
            if (init_done[i] !== 1'b0) begin miscompares++; $display("FAIL reset_init_done[%0d] got %b want 0", i, init_done[i]); end
        end
        obs_q.delete();
        // Read held on instance 0 throughout the sweep; it may only be taken once ready.
        req_we = 1'b0; req_addr = 17'h0; req_wdata = 16'h0; req_be = 2'b00;
        req_valid[0] = 1'b1;
        rst = 1'b0;
        c0 = cyc;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                expd = (i == 3) ? 1'b1 : (k >= 65);
                vectors += 2;
                if (init_done[i] !== expd) begin miscompares++; $display("FAIL clear_init_done[%0d] k=%0d got %b want %b", i, k, init_done[i], expd); end
                if (req_ready[i] !== expd) begin miscompares++; $display("FAIL clear_req_ready[%0d] k=%0d got %b want %b", i, k, req_ready[i], expd); end
            end
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL held_req_count got %0d want 1", obs_q.size());
        end else begin
            vectors += 2;
            if (obs_q[0].inst != 0 || obs_q[0].cyc != c0 + 66) begin miscompares++; $display("FAIL held_req_timing got inst%0d cyc %0d want inst0 cyc %0d", obs_q[0].inst, obs_q[0].cyc, c0 + 66); end
            if (obs_q[0].data !== 16'h0 || obs_q[0].err !== 1'b0) begin miscompares++; $display("FAIL held_req_data got %h/%b want 0000/0", obs_q[0].data, obs_q[0].err); end
        end
    endtask

    task automatic test_clear_content();
        int c;
        obs_q.delete();
        drive(0, 1'b1, 17'h20, 16'hBEEF, 2'b11);
        drive(0, 1'b0, 17'h20, 16'h0, 2'b00);
        idle();
        wait_cycles(2);
        vectors++;
        if (obs_q.size() != 2 || obs_q[1].data !== 16'hBEEF) begin
            miscompares++; $display("FAIL preload_readback got %0d rsps last %h want 2 rsps beef", obs_q.size(), obs_q[obs_q.size()-1].data);
        end
        reset_and_init();
        obs_q.delete();
        c = cyc;
        drive(0, 1'b0, 17'h20, 16'h0, 2'b00);
        idle();
        wait_cycles(2);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL cleared_read_count got %0d want 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0].cyc != c + 1 || obs_q[0].data !== 16'h0 || obs_q[0].err !== 1'b0)
                begin miscompares++; $display("FAIL cleared_read got cyc %0d %h/%b want cyc %0d 0000/0", obs_q[0].cyc, obs_q[0].data, obs_q[0].err, c + 1); end
        end
    endtask

    task automatic test_byte_enables();
        int c;
        logic [15:0] ed [3];
        ed = '{16'h0, 16'h0, 16'hA534};
        obs_q.delete();
        c = cyc;
        drive(0, 1'b1, 17'h4, 16'hA55A, 2'b11);
        drive(0, 1'b1, 17'h4, 16'h1234, 2'b01);
        drive(0, 1'b0, 17'h4, 16'h0, 2'b00);
        idle();
        wait_cycles(3);
        vectors++;
        if (obs_q.size() != 3) begin miscompares++; $display("FAIL be_count got %0d want 3", obs_q.size()); end
        for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].cyc != c + 1 + k || obs_q[k].err !== 1'b0 || obs_q[k].data !== ed[k])
                begin miscompares++; $display("FAIL be_rsp%0d got cyc %0d %h/%b want cyc %0d %h/0", k, obs_q[k].cyc, obs_q[k].data, obs_q[k].err, c + 1 + k, ed[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [15:0] want;
        obs_q.delete();
        c = cyc;
        for (int w = 0; w < 4; w++) drive(1, 1'b1, 17'(w * 2), 16'(w + 1), 2'b11);
        for (int w = 0; w < 4; w++) drive(1, 1'b0, 17'(w * 2), 16'h0, 2'b00);
        idle();
        wait_cycles(5);
        vectors++;
        if (obs_q.size() != 8) begin miscompares++; $display("FAIL b2b_count got %0d want 8", obs_q.size()); end
        for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
            want = (k < 4) ? 16'h0 : 16'(k - 3);
            vectors++;
            if (obs_q[k].inst != 1 || obs_q[k].cyc != c + 3 + k || obs_q[k].err !== 1'b0 || obs_q[k].data !== want)
                begin miscompares++; $display("FAIL b2b_rsp%0d got cyc %0d %h/%b want cyc %0d %h/0", k, obs_q[k].cyc, obs_q[k].data, obs_q[k].err, c + 3 + k, want); end
        end
    endtask

    task automatic test_errors();
        int c;
        logic [15:0] ed [6];
        logic        ee [6];
        ed = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1111};
        ee = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        obs_q.delete();
        c = cyc;
        drive(0, 1'b1, 17'h00000, 16'h1111, 2'b11);
        drive(0, 1'b0, 17'h00003, 16'h0, 2'b00);
        drive(0, 1'b1, 17'h00080, 16'hFFFF, 2'b11);
        drive(0, 1'b1, 17'h00001, 16'hFFFF, 2'b11);
        drive(0, 1'b0, 17'h1FFFE, 16'h0, 2'b00);
        drive(0, 1'b0, 17'h00000, 16'h0, 2'b00);
        idle();
        wait_cycles(3);
        vectors++;
        if (obs_q.size() != 6) begin miscompares++; $display("FAIL err_count got %0d want 6", obs_q.size()); end
        for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].cyc != c + 1 + k || obs_q[k].err !== ee[k] || obs_q[k].data !== ed[k])
                begin miscompares++; $display("FAIL err_rsp%0d got cyc %0d %h/%b want cyc %0d %h/%b", k, obs_q[k].cyc, obs_q[k].data, obs_q[k].err, c + 1 + k, ed[k], ee[k]); end
        end
        vectors++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 16'h1111 || rsp_err[0] !== 1'b0)
            begin miscompares++; $display("FAIL rsp_hold got %b %h/%b want 0 1111/0", rsp_valid[0], rsp_rdata[0], rsp_err[0]); end
    endtask

    task automatic test_reset_midop();
        int c1;
        bit expd;
        obs_q.delete();
        req_we = 1'b0; req_addr = 17'h0; req_be = 2'b00;
        req_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_addr = 17'h2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid[2] = 1'b0;
        #1;
        vectors++;
        if (rsp_valid[2] !== 1'b0) begin miscompares++; $display("FAIL midop_flush got %b want 0", rsp_valid[2]); end
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(32);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c1 = cyc;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            expd = (k >= 65);
            vectors++;
            if (init_done[2] !== expd || req_ready[2] !== expd)
                begin miscompares++; $display("FAIL restart_clear k=%0d got %b/%b want %b", k, init_done[2], req_ready[2], expd); end
        end
        wait_cycles(3);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL midop_stray_rsp got %0d want 0 (cyc %0d from %0d)", obs_q.size(), obs_q[0].cyc, c1); end
    endtask

    task automatic test_no_clear();
        int c;
        obs_q.delete();
        drive(3, 1'b1, 17'd14, 16'h5A5A, 2'b11);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (init_done[3] !== 1'b0) begin miscompares++; $display("FAIL noclr_init_at_release got %b want 0", init_done[3]); end
        @(negedge clk);
        vectors++;
        if (init_done[3] !== 1'b1 || req_ready[3] !== 1'b1) begin miscompares++; $display("FAIL noclr_init_next got %b/%b want 1/1", init_done[3], req_ready[3]); end
        c = cyc;
        drive(3, 1'b0, 17'd14, 16'h0, 2'b00);
        idle();
        wait_cycles(2);
        vectors++;
        if (obs_q.size() != 2) begin
            miscompares++; $display("FAIL noclr_count got %0d want 2", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[1].cyc != c + 1 || obs_q[1].data !== 16'h5A5A || obs_q[1].err !== 1'b0)
                begin miscompares++; $display("FAIL noclr_read got cyc %0d %h/%b want cyc %0d 5a5a/0", obs_q[1].cyc, obs_q[1].data, obs_q[1].err, c + 1); end
        end
    endtask

    task automatic test_random();
        bit          v;
        bit          e;
        int          r;
        int          widx;
        logic [15:0] w;
        reset_and_init();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 64; a++) model_mem[i][a] = 16'h0;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 200; n++) begin
                v = ($urandom_range(0, 9) < 7);
                r = $urandom_range(0, 9);
                widx = $urandom_range(0, 63);
                if (r < 7)       req_addr = 17'(widx * 2);
                else if (r == 7) req_addr = 17'(widx * 2 + 1);
                else             req_addr = 17'($urandom_range(128, 131071));
                req_we    = $urandom_range(0, 1) == 1;
                req_wdata = 16'($urandom);
                req_be    = 2'($urandom_range(0, 3));
                req_valid[i] = v;
                if (v) begin
                    e = req_addr[0] || (req_addr / 2) >= 64;
                    w = 16'h0;
                    if (!e && req_we) begin
                        if (req_be[0]) model_mem[i][req_addr / 2][7:0]  = req_wdata[7:0];
                        if (req_be[1]) model_mem[i][req_addr / 2][15:8] = req_wdata[15:8];
                    end else if (!e) begin
                        w = model_mem[i][req_addr / 2];
                    end
                    exp_q.push_back('{inst: i, cyc: cyc + lat_of(i), err: e, data: w});
                end
                @(posedge clk);
                @(negedge clk);
            end
            idle();
            wait_cycles(5);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k].inst != exp_q[k].inst || obs_q[k].cyc != exp_q[k].cyc ||
                obs_q[k].err !== exp_q[k].err || obs_q[k].data !== exp_q[k].data)
                begin miscompares++; $display("FAIL rand_rsp%0d got inst%0d cyc %0d %h/%b want inst%0d cyc %0d %h/%b", k,
                    obs_q[k].inst, obs_q[k].cyc, obs_q[k].data, obs_q[k].err,
                    exp_q[k].inst, exp_q[k].cyc, exp_q[k].data, exp_q[k].err); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_we = 1'b0; req_addr = 17'h0; req_wdata = 16'h0; req_be = 2'b00;
        idle();
        @(negedge clk);
        test_reset();
        test_clear_content();
        test_byte_enables();
        test_back_to_back();
        test_errors();
        test_reset_midop();
        test_no_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
